fft_sample_loader: RTL and testbench

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_sample_loader_if.sv | 27 ++
 rtl/fft_sample_loader.sv | 122 ++++++++++++
 tb/tb_fft_sample_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants and the sample-loader FSM state encoding, used by the loader,
// the sequencer and the butterfly datapath.
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LEVEL = $clog2(FFT_N);
  localparam int FFT_DW    = 16;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } fft_state_t;

endpackage

// File: rtl/fft_sample_loader_if.sv
// Upstream sample stream into the loader.
// A sample transfers on a rising edge where s_valid && s_ready; a sample that is not
// taken must be held with s_valid high, and s_ready never depends on s_valid.
interface fft_sample_loader_if #(
  parameter int DW = 16
) ();

  logic          s_valid;
  logic          s_ready;
  logic [2*DW-1:0] s_data;
  logic          s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/fft_sample_loader.sv
// Writes one frame of N samples into the initial FFT BRAM in natural order, launches
// the sequencer, and waits for it to finish before accepting the next frame.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LEVEL = $clog2(N),
  parameter int DW    = FFT_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_sample_loader_if.slave   s,
  output logic                 bram_we,
  output logic [LEVEL-1:0]     bram_addr,
  output logic [2*DW-1:0]      bram_wdata,
  output logic                 fft_start,
  input  logic                 fft_busy,
  input  logic                 fft_done,
  output logic                 frame_err,
  output logic [7:0]           frame_cnt,
  output fft_state_t           o_dbg_state
);

  fft_state_t       r_state;
  fft_state_t       w_next;
  logic [LEVEL-1:0] r_count;
  logic             r_bram_we;
  logic [LEVEL-1:0] r_bram_addr;
  logic [2*DW-1:0]  r_bram_wdata;
  logic             r_fft_start;
  logic             r_frame_err;
  logic [7:0]       r_frame_cnt;

  logic w_ready;
  logic w_accept;
  logic w_at_end;
  logic w_early;
  logic w_missing;
  logic w_write;
  logic w_start_pulse;
  logic w_frame_done;

  assign w_ready   = (r_state == LOAD) && !rst;
  assign w_accept  = s.s_valid && w_ready;
  assign w_at_end  = (r_count == LEVEL'(N - 1));
  // An early s_last drops the sample and restarts the frame; a missing one is only flagged.
  assign w_early   = w_accept && s.s_last && !w_at_end;
  assign w_missing = w_accept && !s.s_last && w_at_end;
  assign w_write   = w_accept && !w_early;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_start_pulse = 1'b0;
    w_frame_done  = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_accept && w_at_end) w_next = START;
      end
      START: begin
        w_start_pulse = 1'b1;
        w_next        = WAIT_BUSY;
      end
      // A done flag still high from the previous frame is ignored until busy is seen.
      WAIT_BUSY: begin
        if (fft_busy) w_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fft_done) begin
          w_frame_done = 1'b1;
          w_next       = LOAD;
        end
      end
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
      r_fft_start  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_bram_we   <= w_write;
      r_fft_start <= w_start_pulse;
      r_frame_err <= w_early || w_missing;
      if (w_write) begin
        r_bram_addr  <= r_count;
        r_bram_wdata <= s.s_data;
      end
      if (w_early || w_frame_done) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= r_count + LEVEL'(1);
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign s.s_ready   = w_ready;
  assign bram_we     = r_bram_we;
  assign bram_addr   = r_bram_addr;
  assign bram_wdata  = r_bram_wdata;
  assign fft_start   = r_fft_start;
  assign frame_err   = r_frame_err;
  assign frame_cnt   = r_frame_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: random stimulus, a frame-level reference
// model with expected write/error/start queues, and a simple sequencer responder.
module tb_fft_sample_loader;
  import fft_pkg::*;

  localparam int N     = 16;
  localparam int LEVEL = 4;
  localparam int DW    = 16;
  localparam int W     = 32 + LEVEL + 2 * DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             bram_we;
  logic [LEVEL-1:0] bram_addr;
  logic [2*DW-1:0]  bram_wdata;
  logic             fft_start;
  logic             fft_busy = 1'b0;
  logic             fft_done = 1'b0;
  logic             frame_err;
  logic [7:0]       frame_cnt;
  fft_state_t       dbg_state;

  fft_sample_loader_if #(.DW(DW)) s_if ();

  fft_sample_loader #(.N(N), .LEVEL(LEVEL), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (s_if),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_wdata  (bram_wdata),
    .fft_start   (fft_start),
    .fft_busy    (fft_busy),
    .fft_done    (fft_done),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .o_dbg_state (dbg_state)
  );

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst;
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int err_q[$];
  int start_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int exp_frames = 0;
  bit cnt_pending = 0;
  int m_pos = 0;

  // sequencer responder settings
  int seq_phase = 0;
  int seq_cnt = 0;
  int busy_delay = 2;
  int run_len = 3;

  // Frame-level model: position within the frame decides write / error / start.
  task automatic model_accept(input logic [2*DW-1:0] data, input logic last);
    if (last && m_pos != N - 1) begin
      err_q.push_back(cyc + 1);
      m_pos = 0;
    end else begin
      exp_q.push_back({32'(cyc + 1), LEVEL'(m_pos), data});
      if (m_pos == N - 1) begin
        if (!last) err_q.push_back(cyc + 1);
        start_q.push_back(cyc + 2);
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  // monitor + scoreboard + sequencer responder
  always @(negedge clk) begin
    logic [W-1:0] e;
    bit due_w;
    bit due_e;
    bit due_s;
    if (rst_at_edge) begin
      exp_frames  = 0;
      cnt_pending = 0;
      seq_phase   = 0;
      fft_busy    = 1'b0;
      fft_done    = 1'b0;
    end else if (cnt_pending) begin
      exp_frames++;
      cnt_pending = 0;
    end
    if (cyc > 0) begin
      due_w = (exp_q.size() > 0) && (exp_q[0][W-1 -: 32] == 32'(cyc));
      n_cmp++;
      if (bram_we !== due_w) begin
        n_fail++;
        $display("FAIL bram_we cyc=%0d: got %b expected %b", cyc, bram_we, due_w);
      end
      if (due_w) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bram_addr, bram_wdata} !== e[LEVEL+2*DW-1:0]) begin
          n_fail++;
          $display("FAIL bram_write cyc=%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                   cyc, bram_addr, bram_wdata, e[LEVEL+2*DW-1 -: LEVEL], e[2*DW-1:0]);
        end
      end
      due_e = (err_q.size() > 0) && (err_q[0] == cyc);
      if (due_e) void'(err_q.pop_front());
      n_cmp++;
      if (frame_err !== due_e) begin
        n_fail++;
        $display("FAIL frame_err cyc=%0d: got %b expected %b", cyc, frame_err, due_e);
      end
      due_s = (start_q.size() > 0) && (start_q[0] == cyc);
      if (due_s) void'(start_q.pop_front());
      n_cmp++;
      if (fft_start !== due_s) begin
        n_fail++;
        $display("FAIL fft_start cyc=%0d: got %b expected %b", cyc, fft_start, due_s);
      end
      n_cmp++;
      if (frame_cnt !== exp_frames[7:0]) begin
        n_fail++;
        $display("FAIL frame_cnt cyc=%0d: got %0d expected %0d", cyc, frame_cnt, exp_frames[7:0]);
      end
    end
    if (!rst_at_edge) begin
      if (fft_start === 1'b1) begin
        seq_phase = 1;
        seq_cnt   = busy_delay;
      end else if (seq_phase == 1) begin
        if (seq_cnt == 0) begin
          fft_busy  = 1'b1;
          fft_done  = 1'b0;
          seq_phase = 2;
          seq_cnt   = run_len;
        end else begin
          seq_cnt--;
        end
      end else if (seq_phase == 2) begin
        if (seq_cnt == 0) begin
          fft_busy    = 1'b0;
          fft_done    = 1'b1;
          seq_phase   = 0;
          cnt_pending = 1;
        end else begin
          seq_cnt--;
        end
      end
    end
  end

  // driver: offers samples until count have been accepted
  task automatic drive_samples(input int count, input int last_idx, input int idle_pct);
    int sent = 0;
    int guard = 0;
    bit prev_acc = 0;
    s_if.s_valid = 1'b0;
    while (sent < count && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (prev_acc || !s_if.s_valid) begin
        s_if.s_valid = ($urandom_range(99) >= idle_pct);
        s_if.s_data  = $urandom;
        s_if.s_last  = (sent == last_idx);
      end
      prev_acc = s_if.s_valid && s_if.s_ready;
      if (prev_acc) begin
        model_accept(s_if.s_data, s_if.s_last);
        sent++;
      end
    end
    @(negedge clk);
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    n_cmp++;
    if (sent < count) begin
      n_fail++;
      $display("FAIL drive_timeout: got %0d accepted expected %0d", sent, count);
    end
  endtask

  task automatic wait_load(input string tag);
    int g = 0;
    @(negedge clk);
    while (s_if.s_ready !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (g >= 500) begin
      n_fail++;
      $display("FAIL wait_load_%s: got s_ready=%b expected 1 within 500 cycles", tag, s_if.s_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s_if.s_ready, bram_we, bram_addr, bram_wdata, fft_start, frame_err, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0d data=%h st=%b err=%b cnt=%0d expected all 0",
               s_if.s_ready, bram_we, bram_addr, bram_wdata, fft_start, frame_err, frame_cnt);
    end
    n_cmp++;
    if (dbg_state !== LOAD) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, LOAD);
    end
    rst = 1'b0;
    m_pos = 0;
    @(negedge clk);
    n_cmp++;
    if (s_if.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", s_if.s_ready);
    end
  endtask

  task automatic test_full_frame();
    drive_samples(N, N - 1, 0);
    n_cmp++;
    if (s_if.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_frame_ready_low: got %b expected 0", s_if.s_ready);
    end
    wait_load("full");
    n_cmp++;
    if (frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL full_frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_random_valid();
    for (int f = 0; f < 3; f++) begin
      drive_samples(N, N - 1, 45);
      wait_load("random");
    end
  endtask

  task automatic test_early_last();
    drive_samples(5, 4, 30);
    n_cmp++;
    if (s_if.s_ready !== 1'b1 || dbg_state !== LOAD) begin
      n_fail++;
      $display("FAIL early_last_stays_load: got rdy=%b state=%0d expected rdy=1 state=%0d",
               s_if.s_ready, dbg_state, LOAD);
    end
    drive_samples(N, N - 1, 20);
    wait_load("after_early");
  endtask

  task automatic test_missing_last();
    drive_samples(N, -1, 10);
    wait_load("missing");
  endtask

  task automatic test_stale_done();
    int g = 0;
    busy_delay = 8;
    drive_samples(N, N - 1, 0);
    @(negedge clk);
    #1;
    while (fft_busy !== 1'b1 && g < 100) begin
      n_cmp++;
      if (s_if.s_ready !== 1'b0 || dbg_state == LOAD) begin
        n_fail++;
        $display("FAIL stale_done_early_return: got rdy=%b state=%0d expected rdy=0 not LOAD",
                 s_if.s_ready, dbg_state);
      end
      @(negedge clk);
      #1;
      g++;
    end
    wait_load("stale");
    busy_delay = 2;
  endtask

  task automatic test_reset_mid_frame();
    drive_samples(9, -1, 20);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_pos = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (s_if.s_ready !== 1'b0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_frame_reset: got rdy=%b cnt=%0d expected rdy=0 cnt=0", s_if.s_ready, frame_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_if.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_frame_release_ready: got %b expected 1", s_if.s_ready);
    end
    drive_samples(N, N - 1, 0);
    wait_load("after_reset");
    n_cmp++;
    if (frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL after_reset_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_reset_mid_fft();
    int g = 0;
    run_len = 10;
    drive_samples(N, N - 1, 0);
    @(negedge clk);
    #1;
    while (fft_busy !== 1'b1 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    rst = 1'b1;
    m_pos = 0;
    @(negedge clk);
    rst = 1'b0;
    run_len = 3;
    @(negedge clk);
    n_cmp++;
    if (s_if.s_ready !== 1'b1 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_fft_reset: got rdy=%b cnt=%0d expected rdy=1 cnt=0", s_if.s_ready, frame_cnt);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    busy_delay = 0;
    run_len = 0;
    for (int f = 0; f < 256; f++) begin
      drive_samples(N, N - 1, 0);
      wait_load("wrap");
      if (f == 254) begin
        n_cmp++;
        if (frame_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_at_255: got %0d expected 255", frame_cnt);
        end
      end
    end
    n_cmp++;
    if (frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_to_0: got %0d expected 0", frame_cnt);
    end
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;
    test_reset();
    test_full_frame();
    test_random_valid();
    test_early_last();
    test_missing_last();
    test_stale_done();
    test_reset_mid_frame();
    test_reset_mid_fft();
    test_frame_cnt_wrap();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_q.size() + err_q.size() + start_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: got %0d pending events expected 0",
               exp_q.size() + err_q.size() + start_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
